alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 166 ++++++++++++++++
 tb/tb_alu_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU for the out-of-order execute stage.
// An issued op (operands, op code, ROB tag) is computed in the first stage,
// then carried through PIPE_STAGES-1 pure register stages to the result port.
// The whole pipe advances in lockstep on a valid/ready handshake, so bubbles
// are kept and ordering is preserved. A flush kills everything in flight.

module alu_pipe #(
    parameter int WIDTH       = 32,
    parameter int TAG_W       = 6,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctrl,
    input  logic             in_src_imm,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [TAG_W-1:0] in_tag,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_sign,
    output logic             out_ovf,
    output logic             out_illegal
);

    // Operation encodings.
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1110;

    // Only the low log2(WIDTH) bits of operand B steer the shifter.
    localparam int SHW = $clog2(WIDTH);

    // Everything a stage carries besides its valid bit.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             sign;
        logic             ovf;
        logic             illegal;
    } stage_t;

    // Pipeline state: index 0 is the compute stage, PIPE_STAGES-1 drives the outputs.
    logic [PIPE_STAGES-1:0] st_valid;
    stage_t                 st_data [PIPE_STAGES];

    // Combinational compute of the op presented this cycle.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    stage_t           calc;

    // The whole pipe moves together whenever the result slot is free or is being drained.
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush;

    assign op_a  = in_rs1;
    assign op_b  = in_src_imm ? in_imm : in_rs2;
    assign shamt = op_b[SHW-1:0];
    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;

    // Decode the op code and form the result plus its flags for stage 1.
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        calc         = '0;
        calc.tag     = in_tag;
        calc.result  = op_a;
        calc.illegal = 1'b0;

        case (in_ctrl)
            OP_AND:  calc.result = op_a & op_b;
            OP_OR:   calc.result = op_a | op_b;
            OP_XOR:  calc.result = op_a ^ op_b;
            OP_ADD: begin
                calc.result = sum;
                // Operands agree in sign but the sum does not.
                calc.ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                calc.result = diff;
                // Operands differ in sign and the difference lost A's sign.
                calc.ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                              (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SLL:  calc.result = op_a << shamt;
            OP_SRL:  calc.result = op_a >> shamt;
            OP_SRA:  calc.result = $signed(op_a) >>> shamt;
            OP_SLT:  calc.result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: calc.result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            default: begin
                // Unknown code: pass operand A through and mark it for the ROB.
                calc.result  = op_a;
                calc.illegal = 1'b1;
            end
        endcase

        calc.zero = (calc.result == '0);
        calc.sign = calc.result[WIDTH-1];
    end

    // Pipeline registers: reset beats flush, flush beats a normal advance.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every stage
        // samples its neighbour's pre-edge value and the shift is order-independent.
        if (!rst_n) begin
            st_valid <= '0;
            // NOTE: the data array is small and its last entry is the visible
            // output, so clearing it all on reset is cheap and keeps outputs at zero.
            for (int i = 0; i < PIPE_STAGES; i++) begin
                st_data[i] <= '0;
            end
        end else if (flush) begin
            // Kill all in-flight ops; stale data behind a cleared valid is harmless.
            st_valid <= '0;
        end else if (advance) begin
            st_valid[0] <= in_valid;
            if (in_valid) begin
                st_data[0] <= calc;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_data[i]  <= st_data[i-1];
            end
        end
    end

    assign out_valid   = st_valid[PIPE_STAGES-1];
    assign out_result  = st_data[PIPE_STAGES-1].result;
    assign out_tag     = st_data[PIPE_STAGES-1].tag;
    assign out_zero    = st_data[PIPE_STAGES-1].zero;
    assign out_sign    = st_data[PIPE_STAGES-1].sign;
    assign out_ovf     = st_data[PIPE_STAGES-1].ovf;
    assign out_illegal = st_data[PIPE_STAGES-1].illegal;

    // A presented result from a defined op can never be both zero and negative.
    always_ff @(posedge clk) begin
        if (rst_n && out_valid && !out_illegal) begin
            assert (!(out_zero && out_sign));
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=32, PIPE_STAGES=2).
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.

module tb_alu_pipe;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1110;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic        in_src_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
    logic        out_zero;
    logic        out_sign;
    logic        out_ovf;
    logic        out_illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_pipe #(.WIDTH(32), .TAG_W(6), .PIPE_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_src_imm (in_src_imm),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_sign   (out_sign),
        .out_ovf    (out_ovf),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ctrl, input logic src_imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [5:0] tag);
        in_valid   = 1'b1;
        in_ctrl    = ctrl;
        in_src_imm = src_imm;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_tag     = tag;
    endtask

    // One op through an empty pipe with out_ready high: nothing after 1 edge, result after 2.
    task automatic run_single(input string name, input logic [3:0] ctrl, input logic src_imm,
                              input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [5:0] tag, input logic [31:0] exp_result,
                              input logic exp_zero, input logic exp_sign, input logic exp_ovf,
                              input logic exp_illegal);
        out_ready = 1'b1;
        drive(ctrl, src_imm, rs1, rs2, imm, tag);
        #1;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check({name, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check({name, "_valid"},   32'(out_valid),   32'd1);
        check({name, "_result"},  out_result,       exp_result);
        check({name, "_tag"},     32'(out_tag),     32'(tag));
        check({name, "_zero"},    32'(out_zero),    32'(exp_zero));
        check({name, "_sign"},    32'(out_sign),    32'(exp_sign));
        check({name, "_ovf"},     32'(out_ovf),     32'(exp_ovf));
        check({name, "_illegal"}, 32'(out_illegal), 32'(exp_illegal));
        tick();
        check({name, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int k;
        int idx;

        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        in_ctrl    = 4'd0;
        in_src_imm = 1'b0;
        in_rs1     = 32'd0;
        in_rs2     = 32'd0;
        in_imm     = 32'd0;
        in_tag     = 6'd0;

        // Reset state.
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_result",    out_result,       32'd0);
        check("rst_tag",       32'(out_tag),     32'd0);
        check("rst_zero",      32'(out_zero),    32'd0);
        check("rst_sign",      32'(out_sign),    32'd0);
        check("rst_ovf",       32'(out_ovf),     32'd0);
        check("rst_illegal",   32'(out_illegal), 32'd0);
        check("rst_in_ready",  32'(in_ready),    32'd1);

        // Single ops: name, ctrl, imm?, rs1, rs2, imm, tag, result, zero, sign, ovf, illegal.
        run_single("add_ovf",  OP_ADD,  1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0,  6'd5,
                   32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        run_single("sub_zero", OP_SUB,  1'b1, 32'h0000_0005, 32'h0000_0123, 32'h5,  6'd6,
                   32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_single("sub_ovf",  OP_SUB,  1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0,  6'd7,
                   32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        run_single("sra",      OP_SRA,  1'b0, 32'h8000_0000, 32'h0000_0024, 32'h0,  6'd8,
                   32'hF800_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_single("srl",      OP_SRL,  1'b1, 32'h8000_0000, 32'h0,         32'h21, 6'd9,
                   32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_single("sll",      OP_SLL,  1'b0, 32'h0000_0001, 32'h0000_001F, 32'h0,  6'd10,
                   32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_single("slt",      OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,  6'd11,
                   32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_single("sltu",     OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,  6'd12,
                   32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_single("and",      OP_AND,  1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0,  6'd13,
                   32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_single("or",       OP_OR,   1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0,  6'd14,
                   32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_single("xor",      OP_XOR,  1'b0, 32'h8000_F0F0, 32'h0000_FF00, 32'h0,  6'd15,
                   32'h8000_0FF0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_single("illegal",  OP_BAD,  1'b0, 32'h0000_0012, 32'h0000_0034, 32'h0,  6'd16,
                   32'h0000_0012, 1'b0, 1'b0, 1'b0, 1'b1);

        // Eight back-to-back ADDs (op k: 100+k + k, tag 10+k), out_ready low in cycles 3..5.
        // Ops 0..2 accepted in cycles 0..2; op 3 held during the stall, accepted in cycle 6;
        // op k>=3 accepted in cycle k+3. Outputs: op0 @2, op1 @3..6, op k>=2 @ k+5.
        for (int c = 0; c < 15; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            if (c < 3)       k = c;
            else if (c <= 5) k = 3;
            else if (c <= 10) k = c - 3;
            else             k = -1;
            if (k >= 0) drive(OP_ADD, 1'b0, 32'(100 + k), 32'(k), 32'h0, 6'(10 + k));
            else        in_valid = 1'b0;
            #1;
            check("b2b_in_ready", 32'(in_ready), (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
            if (c == 2)                  idx = 0;
            else if (c >= 3 && c <= 6)   idx = 1;
            else if (c >= 7 && c <= 12)  idx = c - 5;
            else                         idx = -1;
            check("b2b_out_valid", 32'(out_valid), (idx >= 0) ? 32'd1 : 32'd0);
            if (idx >= 0) begin
                check("b2b_result", out_result,   32'(100 + 2 * idx));
                check("b2b_tag",    32'(out_tag), 32'(10 + idx));
            end
            tick();
        end

        // Flush with two ops in flight (oldest stalled at the output) and a third presented.
        out_ready = 1'b0;
        drive(OP_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 6'd20);
        tick();
        drive(OP_ADD, 1'b0, 32'd2, 32'd2, 32'd0, 6'd21);
        tick();
        drive(OP_ADD, 1'b0, 32'd3, 32'd3, 32'd0, 6'd22);
        flush = 1'b1;
        #1;
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        check("flush_pre_tag",   32'(out_tag),   32'd20);
        check("flush_in_ready",  32'(in_ready),  32'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_ready_back", 32'(in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("flush_no_result", 32'(out_valid), 32'd0);
        end

        // One-cycle reset with the pipe full and the output stalled.
        out_ready = 1'b0;
        drive(OP_ADD, 1'b0, 32'd7, 32'd8, 32'd0, 6'd30);
        tick();
        drive(OP_ADD, 1'b0, 32'd9, 32'd9, 32'd0, 6'd31);
        tick();
        drive(OP_ADD, 1'b0, 32'd4, 32'd4, 32'd0, 6'd32);
        #1;
        check("mrst_pre_valid",  32'(out_valid), 32'd1);
        check("mrst_pre_result", out_result,     32'd15);
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid),   32'd0);
        check("mrst_result",    out_result,       32'd0);
        check("mrst_tag",       32'(out_tag),     32'd0);
        check("mrst_flags",     32'({out_zero, out_sign, out_ovf, out_illegal}), 32'd0);
        check("mrst_in_ready",  32'(in_ready),    32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mrst_no_result", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
